// File: rtl/spi_master.sv
// spi_master: single-byte SPI mode-0 (CPOL=0, CPHA=0) master, MSB first.
// sck half-period is CLK_DIV clk cycles; all outputs are registered.
// Optional build macro SPI_MASTER_BURST_EN: a request arriving on the last
// falling edge chains the next byte into the same cs frame.
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in_valid,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       data_out_valid,
    output logic [7:0] data_out,
    output logic       sck,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       tx_q, tx_d;     // bits still to be driven after the current one
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       dout_q, dout_d;
    logic             dov_q, dov_d;
    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             div_done;
`ifdef SPI_MASTER_BURST_EN
    logic             cap_q, cap_d;   // last bit of a byte was just sampled
`endif

    assign div_done = (div_q == DIV_LAST);

    // Next-state and next-output logic; every phase lasts CLK_DIV clks.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        dov_d   = 1'b0;
        busy_d  = busy_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        div_d   = (state_q == IDLE || div_done) ? '0 : div_q + CNT_W'(1);
`ifdef SPI_MASTER_BURST_EN
        cap_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (data_in_valid) begin
                    tx_d    = data_in[6:0];
                    mosi_d  = data_in[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (div_done) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_done) begin
                    sck_d = 1'b0;
                    rx_d  = {rx_q[6:0], miso};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SPI_MASTER_BURST_EN
                        cap_d = 1'b1;
                        if (data_in_valid) begin
                            tx_d    = data_in[6:0];
                            mosi_d  = data_in[7];
                            state_d = LOW;
                        end else begin
                            state_d = TRAIL;
                        end
`else
                        state_d = TRAIL;
`endif
                    end else begin
                        mosi_d  = tx_q[6];
                        tx_d    = {tx_q[5:0], 1'b0};
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (div_done) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            TRAIL: begin
                if (div_done) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
`ifndef SPI_MASTER_BURST_EN
                    dout_d  = rx_q;
                    dov_d   = 1'b1;
`endif
                    state_d = GAP;
                end
            end
            GAP: begin
                if (div_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SPI_MASTER_BURST_EN
        // Present each byte one clk after its final sample, frame continuing or not.
        if (cap_q) begin
            dout_d = rx_q;
            dov_d  = 1'b1;
        end
`endif
    end

    // State and output registers; reset aborts silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 7'd0;
            rx_q    <= 8'h00;
            dout_q  <= 8'h00;
            dov_q   <= 1'b0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            cap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            dov_q   <= dov_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
`ifdef SPI_MASTER_BURST_EN
            cap_q   <= cap_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign data_out_valid = dov_q;
    assign data_out       = dout_q;
    assign sck            = sck_q;
    assign cs             = cs_q;
    assign mosi           = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench with scoreboard monitors for spi_master.
`timescale 1ns/1ps
module tb_spi_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // CLK_DIV=2 instance
    logic       v2, busy2, dov2, sck2, cs2, mosi2;
    logic       miso2 = 1'b0;
    logic [7:0] din2, dout2;
    spi_master #(.CLK_DIV(2)) u_div2 (
        .clk(clk), .rst(rst), .data_in_valid(v2), .data_in(din2),
        .busy(busy2), .data_out_valid(dov2), .data_out(dout2),
        .sck(sck2), .cs(cs2), .mosi(mosi2), .miso(miso2)
    );

    // CLK_DIV=1 instance
    logic       v1, busy1, dov1, sck1, cs1, mosi1;
    logic       miso1 = 1'b0;
    logic [7:0] din1, dout1;
    spi_master #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .data_in_valid(v1), .data_in(din1),
        .busy(busy1), .data_out_valid(dov1), .data_out(dout1),
        .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(miso1)
    );

    // Slave models: sample mosi and update miso on sck rise, restart on cs fall.
    logic [7:0] s2_tx = 8'h00, s2_rx = 8'h00, s1_tx = 8'h00, s1_rx = 8'h00;
    logic [2:0] s2_idx = 3'd0, s1_idx = 3'd0;

    always @(negedge cs2 or posedge sck2) begin
        if (sck2) begin
            s2_rx  = {s2_rx[6:0], mosi2};
            miso2 <= s2_tx[3'd7 - s2_idx];
            s2_idx = s2_idx + 3'd1;
        end else begin
            s2_idx = 3'd0;
        end
    end

    always @(negedge cs1 or posedge sck1) begin
        if (sck1) begin
            s1_rx  = {s1_rx[6:0], mosi1};
            miso1 <= s1_tx[3'd7 - s1_idx];
            s1_idx = s1_idx + 3'd1;
        end else begin
            s1_idx = 3'd0;
        end
    end

    // Selected instance for the generic transfer task
    logic sel = 1'b0;
    logic c_cs, c_sck, c_busy, c_dov, c_mosi;
    assign c_cs   = sel ? cs1   : cs2;
    assign c_sck  = sel ? sck1  : sck2;
    assign c_busy = sel ? busy1 : busy2;
    assign c_dov  = sel ? dov1  : dov2;
    assign c_mosi = sel ? mosi1 : mosi2;

    // Scoreboards: {expected data_out, expected byte seen by slave}
    logic [15:0] q2[$];
    logic [15:0] q1[$];
    logic [15:0] e2, e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a byte is presented
    always @(negedge clk) begin
        if (dov2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL div2_unexpected_valid: got data_out=%0h required no pulse", dout2);
            end else begin
                e2 = q2.pop_front();
                chk("div2_data_out", 32'(dout2), 32'(e2[15:8]));
                chk("div2_slave_rx", 32'(s2_rx), 32'(e2[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (dov1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL div1_unexpected_valid: got data_out=%0h required no pulse", dout1);
            end else begin
                e1 = q1.pop_front();
                chk("div1_data_out", 32'(dout1), 32'(e1[15:8]));
                chk("div1_slave_rx", 32'(s1_rx), 32'(e1[7:0]));
            end
        end
    end

`ifdef SPI_MASTER_BURST_EN
    // CLK_DIV=4 instance for chained bytes
    logic        v4 = 1'b0, busy4, dov4, sck4, cs4, mosi4;
    logic        miso4 = 1'b0;
    logic [7:0]  din4 = 8'h00, dout4;
    logic [15:0] s4_tx = 16'h0000, s4_rx = 16'h0000, e4;
    logic [3:0]  s4_idx = 4'd0;
    logic [15:0] q4[$];
    spi_master #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .data_in_valid(v4), .data_in(din4),
        .busy(busy4), .data_out_valid(dov4), .data_out(dout4),
        .sck(sck4), .cs(cs4), .mosi(mosi4), .miso(miso4)
    );

    always @(negedge cs4 or posedge sck4) begin
        if (sck4) begin
            s4_rx  = {s4_rx[14:0], mosi4};
            miso4 <= s4_tx[4'd15 - s4_idx];
            s4_idx = s4_idx + 4'd1;
        end else begin
            s4_idx = 4'd0;
        end
    end

    always @(negedge clk) begin
        if (dov4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL div4_unexpected_valid: got data_out=%0h required no pulse", dout4);
            end else begin
                e4 = q4.pop_front();
                chk("div4_data_out", 32'(dout4), 32'(e4[15:8]));
                chk("div4_slave_rx", 32'(s4_rx[7:0]), 32'(e4[7:0]));
            end
        end
    end
`endif

    task automatic drive_req(input logic v, input logic [7:0] d);
        if (sel) begin
            v1 = v; din1 = d;
        end else begin
            v2 = v; din2 = d;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (c_busy !== 1'b0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (c_busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: busy=%b required 0", c_busy);
        end
        repeat (3) @(posedge clk);
    endtask

    // One transfer on the selected instance, checking every clk against the edge schedule.
    task automatic xfer(input logic [7:0] din, input logic [7:0] sret,
                        input bit hold, input logic [7:0] din_b);
        int cd;
        int dov_n;
        int h;
        logic exp_sck;
        cd = sel ? 1 : 2;
`ifdef SPI_MASTER_BURST_EN
        dov_n = 16 * cd + 1;
`else
        dov_n = 17 * cd;
`endif
        if (sel) begin
            s1_tx = sret; q1.push_back({sret, din});
        end else begin
            s2_tx = sret; q2.push_back({sret, din});
        end
        @(negedge clk);
        drive_req(1'b1, din);
        @(posedge clk); #1;
        chk("accept_cs", 32'(c_cs), 32'd0);
        chk("accept_busy", 32'(c_busy), 32'd1);
        chk("accept_sck", 32'(c_sck), 32'd0);
        chk("accept_mosi", 32'(c_mosi), 32'(din[7]));
        if (hold) drive_req(1'b1, din_b);
        else      drive_req(1'b0, din);
        for (int n = 1; n <= 18 * cd; n++) begin
            @(posedge clk); #1;
            h = n / cd;
            exp_sck = ((h % 2) == 1) && (h <= 15);
            chk($sformatf("sck@T0+%0d", n), 32'(c_sck), 32'(exp_sck));
            chk($sformatf("cs@T0+%0d", n), 32'(c_cs), 32'(n >= 17 * cd));
            chk($sformatf("busy@T0+%0d", n), 32'(c_busy), 32'(n < 18 * cd));
            chk($sformatf("valid@T0+%0d", n), 32'(c_dov), 32'(n == dov_n));
            if (exp_sck)
                chk($sformatf("mosi@T0+%0d", n), 32'(c_mosi), 32'(din[7 - (h - 1) / 2]));
        end
        if (hold) begin
            if (sel) q1.push_back({sret, din_b});
            else     q2.push_back({sret, din_b});
            @(posedge clk); #1;
            chk("reaccept_busy", 32'(c_busy), 32'd1);
            chk("reaccept_cs", 32'(c_cs), 32'd0);
            drive_req(1'b0, din_b);
        end
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b0; v2 = 1'b0; din1 = 8'h00; din2 = 8'h00;
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", 32'(cs2), 32'd1);
        chk("rst_sck", 32'(sck2), 32'd0);
        chk("rst_mosi", 32'(mosi2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_valid", 32'(dov2), 32'd0);
        chk("rst_data_out", 32'(dout2), 32'h00);
        chk("rst1_cs", 32'(cs1), 32'd1);
        chk("rst1_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: no requests for 100 clks
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            chk("idle_sck", 32'(sck2), 32'd0);
            chk("idle_cs", 32'(cs2), 32'd1);
            chk("idle_mosi", 32'(mosi2), 32'd0);
            chk("idle_busy", 32'(busy2), 32'd0);
        end

        // CLK_DIV=2, A5 out, 3C back
        sel = 1'b0;
        xfer(8'hA5, 8'h3C, 1'b0, 8'h00);

`ifndef SPI_MASTER_BURST_EN
        // Request held through the transfer with data_in changed
        xfer(8'hA5, 8'h3C, 1'b1, 8'hFF);
`endif

        // CLK_DIV=1, zeros out, miso all ones
        sel = 1'b1;
        xfer(8'h00, 8'hFF, 1'b0, 8'h00);

        // Asynchronous reset mid-transfer, then a clean transfer
        sel = 1'b0;
        s2_tx = 8'hC3;
        @(negedge clk);
        v2 = 1'b1; din2 = 8'h99;
        @(posedge clk); #1;
        v2 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_cs", 32'(cs2), 32'd1);
        chk("abort_sck", 32'(sck2), 32'd0);
        chk("abort_busy", 32'(busy2), 32'd0);
        chk("abort_mosi", 32'(mosi2), 32'd0);
        chk("abort_data_out", 32'(dout2), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        xfer(8'h81, 8'h5A, 1'b0, 8'h00);

`ifdef SPI_MASTER_BURST_EN
        begin
            int cs_low, rises, dv_a, dv_b, busy_n;
            logic prev;
            cs_low = 0; rises = 0; dv_a = -1; dv_b = -1; busy_n = -1; prev = 1'b0;
            s4_tx = 16'hA75E;
            q4.push_back({8'hA7, 8'h12});
            q4.push_back({8'h5E, 8'h34});
            @(negedge clk);
            v4 = 1'b1; din4 = 8'h12;
            @(posedge clk); #1;
            din4 = 8'h34;
            if (cs4 == 1'b0) cs_low++;
            for (int n = 1; n <= 200; n++) begin
                @(posedge clk); #1;
                if (n == 64) v4 = 1'b0;
                if (cs4 == 1'b0) cs_low++;
                if (sck4 && !prev) rises++;
                prev = sck4;
                if (dov4) begin
                    if (dv_a < 0) dv_a = n;
                    else          dv_b = n;
                end
                if (!busy4) begin
                    busy_n = n;
                    break;
                end
            end
            chk("burst_cs_low", 32'(cs_low), 32'd132);
            chk("burst_sck_pulses", 32'(rises), 32'd16);
            chk("burst_valid_a", 32'(dv_a), 32'd65);
            chk("burst_valid_b", 32'(dv_b), 32'd129);
            chk("burst_busy_low", 32'(busy_n), 32'd136);
            chk("burst_pending", 32'(q4.size()), 32'd0);
        end
`endif

        repeat (5) @(posedge clk);
        chk("div2_pending", 32'(q2.size()), 32'd0);
        chk("div1_pending", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
